restoring_divider_16: RTL

RESTORING_DIVIDER_16 -- requirements
Module: restoring_divider_16

---
 rtl/restoring_divider_16.sv | 135 +++++++++++++
 1 files changed

// File: rtl/restoring_divider_16.sv
// rtl/restoring_divider_16.sv - Multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Purpose: divides an N-bit unsigned dividend by an N-bit unsigned divisor using
// the restoring algorithm. A request is accepted on the edge where the block is
// idle and start=1. N iterations follow, and then results are presented with a
// one-cycle done pulse. A zero divisor is resolved at acceptance without iterating.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request pulse; sampled only while idle
//   dividend     unsigned numerator, sampled with start
//   divisor      unsigned denominator, sampled with start
//   busy         high while a division is iterating
//   done         one-cycle pulse; quotient/remainder/div_by_zero valid
//   quotient     registered quotient, held until the next done or reset
//   remainder    registered remainder, held until the next done or reset
//   div_by_zero  set with the done of a zero-divisor request, held with results

module restoring_divider_16 #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    rem_q;
    logic [N-1:0]    quo_q;
    logic [N-1:0]    dvs_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;
    logic [N-1:0]    quotient_q;
    logic [N-1:0]    remainder_q;

    logic [N:0]      shifted;
    logic [N:0]      trial;
    logic [N-1:0]    rem_d;
    logic [N-1:0]    quo_d;
    logic            last_iter;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor; a clear borrow bit means the subtraction fits.
    always_comb begin
        shifted = {rem_q, quo_q[N-1]};
        trial   = shifted - {1'b0, dvs_q};
        rem_d   = shifted[N-1:0];
        quo_d   = {quo_q[N-2:0], 1'b0};
        if (!trial[N]) begin
            rem_d = trial[N-1:0];
            quo_d = {quo_q[N-2:0], 1'b1};
        end
    end

    assign last_iter = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvs_q <= divisor;
                        quo_q <= dividend;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            // Resolved immediately: no iterations, stay idle.
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        // Only the final step's values ever reach the outputs.
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dbz_q       <= 1'b0;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

endmodule
